// File: rtl/adder_accumulator.sv
// adder_accumulator: valid/ready front/back end wrapped around a 16-bit
// combinational adder. Accumulates a stream of operands into a low word,
// counts adder carries into a high word, and holds the {high, low} total
// with the beat count on the output handshake after the last beat.
//
// state | meaning
// ------+-----------------------------------------------------------
// ACC   | accepting operand beats, accumulating into low/high words
// DONE  | result held on out_*, input blocked until out handshake
module adder_accumulator #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [15:0]             in_data,
    input  logic                    in_last,
    output logic [15:0]             adder_a,
    output logic [15:0]             adder_b,
    input  logic [15:0]             adder_answer,
    input  logic                    adder_carry,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [16+CNT_WIDTH-1:0] out_sum,
    output logic [CNT_WIDTH-1:0]    out_count,
    output logic                    out_overflow
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [15:0]            r_low;
    logic [CNT_WIDTH-1:0]   r_cnt_hi;
    logic [CNT_WIDTH-1:0]   r_beats;
    logic                   r_ovf;
    logic                   w_accept;
    logic                   w_release;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; reset masks both handshakes so
    // nothing is accepted or offered while a stream is being discarded
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_ACC: begin
                in_ready = ~rst;
                w_accept = in_valid & ~rst;
                if (w_accept && in_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = ~rst;
                w_release = out_ready & ~rst;
                if (w_release) begin
                    w_state_nxt = ST_ACC;
                end
            end
            default: begin
                w_state_nxt = ST_ACC;
            end
        endcase
    end

    // Accumulator datapath: clear on reset or result release, update on accept
    always_ff @(posedge clk) begin
        if (rst || w_release) begin
            r_low    <= '0;
            r_cnt_hi <= '0;
            r_beats  <= '0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_low    <= adder_answer;
            r_cnt_hi <= r_cnt_hi + CNT_WIDTH'(adder_carry);
            if ((&r_cnt_hi) && adder_carry) begin
                r_ovf <= 1'b1;
            end
            if (~&r_beats) begin
                r_beats <= r_beats + 1'b1;
            end
        end
    end

    // The adder is combinational, so its answer is consumed in the same cycle
    assign adder_a      = r_low;
    assign adder_b      = in_data;
    assign out_sum      = {r_cnt_hi, r_low};
    assign out_count    = r_beats;
    assign out_overflow = r_ovf;

endmodule

// File: tb/tb_adder_accumulator.sv
// Self-checking bench for adder_accumulator with a behavioural adder model.
module tb_adder_accumulator;

    logic        clk = 1'b0;
    logic        rst;

    // DUT with default CNT_WIDTH
    logic        in_valid, in_ready, in_last;
    logic [15:0] in_data, adder_a, adder_b, adder_answer;
    logic        adder_carry;
    logic        out_valid, out_ready, out_overflow;
    logic [31:0] out_sum;
    logic [15:0] out_count;

    // DUT with CNT_WIDTH=2 for overflow/saturation
    logic        in_valid2, in_ready2, in_last2;
    logic [15:0] in_data2, adder_a2, adder_b2, adder_answer2;
    logic        adder_carry2;
    logic        out_valid2, out_ready2, out_overflow2;
    logic [17:0] out_sum2;
    logic [1:0]  out_count2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] sum;
        logic [15:0] cnt;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic [15:0] exp_a;
        logic [31:0] exp_sum;
        logic [15:0] exp_cnt;
    } vec_t;

    always #5 clk = ~clk;

    assign {adder_carry, adder_answer}   = {1'b0, adder_a} + {1'b0, adder_b};
    assign {adder_carry2, adder_answer2} = {1'b0, adder_a2} + {1'b0, adder_b2};

    adder_accumulator #(.CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .adder_a(adder_a), .adder_b(adder_b),
        .adder_answer(adder_answer), .adder_carry(adder_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_overflow(out_overflow)
    );

    adder_accumulator #(.CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_last(in_last2),
        .adder_a(adder_a2), .adder_b(adder_b2),
        .adder_answer(adder_answer2), .adder_carry(adder_carry2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_sum(out_sum2), .out_count(out_count2), .out_overflow(out_overflow2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] s, input logic [15:0] c, input logic o);
        exp_t e;
        e.sum = s;
        e.cnt = c;
        e.ovf = o;
        sb_q.push_back(e);
    endtask

    // Drive one beat, wait (bounded) until it is accepted; returns adder_a
    // as seen in the accepting cycle. Returns just after the accepting edge.
    task automatic send_beat(input logic [15:0] d, input logic l, output logic [15:0] a_seen);
        bit ok = 1'b0;
        a_seen   = 'x;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                a_seen = adder_a;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    endtask

    // Scoreboard: compare each completed output handshake with the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got sum %0h, expected no result", out_sum);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result_sum", out_sum, e.sum);
                chk("result_count", out_count, e.cnt);
                chk("result_ovf", out_overflow, e.ovf);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[8];
        logic [15:0] a_seen;
        logic [31:0] msum;
        int          len;

        vecs[0] = '{16'h1234, 1'b1, 16'h0000, 32'h0000_1234, 16'd1};
        vecs[1] = '{16'hFFFF, 1'b0, 16'h0000, 32'h0, 16'd0};
        vecs[2] = '{16'h0001, 1'b0, 16'hFFFF, 32'h0, 16'd0};
        vecs[3] = '{16'h0002, 1'b1, 16'h0000, 32'h0001_0002, 16'd3};
        vecs[4] = '{16'h8000, 1'b0, 16'h0000, 32'h0, 16'd0};
        vecs[5] = '{16'h8000, 1'b0, 16'h8000, 32'h0, 16'd0};
        vecs[6] = '{16'h8000, 1'b1, 16'h0000, 32'h0001_8000, 16'd3};
        vecs[7] = '{16'h0005, 1'b1, 16'h0000, 32'h0000_0005, 16'd1};

        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        in_valid2 = 1'b0; in_data2 = '0; in_last2 = 1'b0; out_ready2 = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_sum", out_sum, 32'h0);
        chk("reset_count", out_count, 16'h0);
        chk("reset_ovf", out_overflow, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;

        // Table-driven streams, back-to-back, out_ready held high
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].last) push_exp(vecs[i].exp_sum, vecs[i].exp_cnt, 1'b0);
            send_beat(vecs[i].data, vecs[i].last, a_seen);
            chk($sformatf("adder_a_vec%0d", i), a_seen, vecs[i].exp_a);
        end
        drain();

        // Single beat: one-cycle latency, then registers cleared and ready again
        push_exp(32'h0000_1234, 16'd1, 1'b0);
        send_beat(16'h1234, 1'b1, a_seen);
        @(negedge clk);
        chk("single_out_valid", out_valid, 1'b1);
        chk("single_in_ready_done", in_ready, 1'b0);
        @(negedge clk);
        chk("single_after_in_ready", in_ready, 1'b1);
        chk("single_after_out_valid", out_valid, 1'b0);
        chk("single_after_sum", out_sum, 32'h0);
        chk("single_after_count", out_count, 16'h0);
        @(posedge clk); #1;

        // Backpressure: result held while input keeps offering data
        out_ready = 1'b0;
        push_exp(32'h0000_0003, 16'd1, 1'b0);
        send_beat(16'h0003, 1'b1, a_seen);
        in_valid = 1'b1; in_data = 16'h0005; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_sum", out_sum, 32'h0000_0003);
            chk("bp_count", out_count, 16'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        push_exp(32'h0000_0005, 16'd1, 1'b0);
        send_beat(16'h0005, 1'b1, a_seen);
        drain();

        // Reset mid-stream discards partial accumulation
        send_beat(16'h0100, 1'b0, a_seen);
        send_beat(16'h0200, 1'b0, a_seen);
        rst = 1'b1; in_valid = 1'b1; in_data = 16'hAAAA; in_last = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        chk("midrst_count", out_count, 16'h0);
        chk("midrst_sum", out_sum, 32'h0);
        @(posedge clk); #1;
        push_exp(32'h0000_0010, 16'd1, 1'b0);
        send_beat(16'h0010, 1'b1, a_seen);
        drain();

        // Bubbles leave the accumulator untouched
        send_beat(16'h0003, 1'b0, a_seen);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bubble_adder_a", adder_a, 16'h0003);
            chk("bubble_count", out_count, 16'd1);
        end
        @(posedge clk); #1;
        push_exp(32'h0000_0007, 16'd2, 1'b0);
        send_beat(16'h0004, 1'b1, a_seen);
        drain();

        // Random streams against a plain running-sum model
        for (int s = 0; s < 4; s++) begin
            len  = $urandom_range(1, 6);
            msum = '0;
            for (int b = 0; b < len; b++) begin
                logic [15:0] d;
                d = 16'($urandom);
                msum = msum + 32'(d);
                if (b == len - 1) push_exp(msum, 16'(len), 1'b0);
                send_beat(d, b == len - 1, a_seen);
                if ($urandom_range(0, 1) == 1) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
            end
        end
        drain();

        // CNT_WIDTH=2: carry count wraps, beat count saturates
        for (int i = 0; i < 5; i++) begin
            in_valid2 = 1'b1; in_data2 = 16'hFFFF; in_last2 = (i == 4);
            @(negedge clk);
            chk("ovf_in_ready", in_ready2, 1'b1);
            @(posedge clk); #1;
        end
        in_valid2 = 1'b0; in_last2 = 1'b0;
        @(negedge clk);
        chk("ovf_out_valid", out_valid2, 1'b1);
        chk("ovf_sum", out_sum2, 18'h0FFFB);
        chk("ovf_count_sat", out_count2, 2'd3);
        chk("ovf_flag", out_overflow2, 1'b1);
        @(posedge clk); #1;
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;
        in_valid2 = 1'b1; in_data2 = 16'h0001; in_last2 = 1'b1;
        @(negedge clk);
        chk("ovf_next_in_ready", in_ready2, 1'b1);
        @(posedge clk); #1;
        in_valid2 = 1'b0; in_last2 = 1'b0;
        @(negedge clk);
        chk("ovf_next_valid", out_valid2, 1'b1);
        chk("ovf_next_sum", out_sum2, 18'h00001);
        chk("ovf_next_count", out_count2, 2'd1);
        chk("ovf_next_flag", out_overflow2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
